// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache controller:
// FSM state encodings, address-field width helpers and field extraction.
package dcache_pkg;

    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    function automatic int off_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Everything above the index and word offset (and the 2 byte bits) is tag.
    function automatic int tag_width(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: asynchronously cleared valid bits plus unreset tags and data,
// one combinational read port and synchronous word / tag-valid write ports.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [idx_width(LINES)-1:0]                  rd_idx_i,
    input  logic [off_width(WORDS_PER_LINE)-1:0]         rd_off_i,
    output logic                                         rd_valid_o,
    output logic [tag_width(LINES, WORDS_PER_LINE)-1:0]  rd_tag_o,
    output logic [31:0]                                  rd_word_o,
    input  logic                                         word_we_i,
    input  logic [idx_width(LINES)-1:0]                  wr_idx_i,
    input  logic [off_width(WORDS_PER_LINE)-1:0]         wr_off_i,
    input  logic [31:0]                                  wr_word_i,
    input  logic                                         fill_we_i,
    input  logic [tag_width(LINES, WORDS_PER_LINE)-1:0]  fill_tag_i
);
    localparam int TAG_W = tag_width(LINES, WORDS_PER_LINE);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (fill_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[wr_idx_i] <= fill_tag_i;
        end
        if (word_we_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, read-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_WDATA,
    output logic [31:0] CPU_RDATA,
    output logic        STALL,
    output logic        MEM_RD,
    output logic        MEM_WR,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] HIT_CNT,
    output logic [31:0] MISS_CNT
`endif
);
    localparam int OFF_W   = off_width(WORDS_PER_LINE);
    localparam int IDX_W   = idx_width(LINES);
    localparam int TAG_W   = tag_width(LINES, WORDS_PER_LINE);
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_W + OFF_W + 2;

    logic [1:0]       state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [OFF_W-1:0] off, wr_off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag, rd_tag;
    logic [31:0]      rd_word, wr_word;
    logic             rd_valid, hit, word_we, fill_we;

    assign off = OFF_W'(addr_field(CPU_ADDR, 2));
    assign idx = IDX_W'(addr_field(CPU_ADDR, IDX_LSB));
    assign tag = TAG_W'(addr_field(CPU_ADDR, TAG_LSB));
    assign hit = rd_valid && (rd_tag == tag);

    // Refill beats land at the counter offset; store hits land at the CPU offset.
    assign wr_off  = (state_q == S_REFILL) ? cnt_q : off;
    assign wr_word = (state_q == S_REFILL) ? MEM_RDATA : CPU_WDATA;

    dcache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (idx),
        .rd_off_i   (off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_word_o  (rd_word),
        .word_we_i  (word_we),
        .wr_idx_i   (idx),
        .wr_off_i   (wr_off),
        .wr_word_i  (wr_word),
        .fill_we_i  (fill_we),
        .fill_tag_i (tag)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        STALL     = 1'b0;
        CPU_RDATA = '0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        word_we   = 1'b0;
        fill_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CPU_WR) begin
                    STALL   = 1'b1;
                    state_d = S_WRITE;
                end else if (CPU_RD) begin
                    if (hit) begin
                        CPU_RDATA = rd_word;
                    end else begin
                        STALL   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                STALL    = 1'b1;
                MEM_RD   = 1'b1;
                MEM_ADDR = {CPU_ADDR[31:OFF_W+2], cnt_q, 2'b00};
                if (MEM_READY) begin
                    word_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    if (&cnt_q) begin
                        fill_we = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                STALL     = !MEM_READY;
                MEM_WR    = 1'b1;
                MEM_ADDR  = {CPU_ADDR[31:2], 2'b00};
                MEM_WDATA = CPU_WDATA;
                if (MEM_READY) begin
                    word_we = hit;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        post_refill_q;

    // The hit that completes a refilled load is not counted as a hit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            post_refill_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && CPU_RD && !CPU_WR) begin
                if (!hit) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end else if (!post_refill_q) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end
            post_refill_q <= (state_q == S_REFILL) && (state_d == S_IDLE);
        end
    end

    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: table of CPU accesses plus hand-written
// slow-memory and reset-during-refill sequences, with a memory-request scoreboard.
module tb_dcache_ctrl;
    localparam int WPL = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_RD, CPU_WR;
    logic [31:0] CPU_ADDR, CPU_WDATA, CPU_RDATA;
    logic        STALL, MEM_RD, MEM_WR;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic        MEM_READY;
`ifdef DCACHE_STATS_EN
    logic [31:0] HIT_CNT, MISS_CNT;
`endif

    dcache_ctrl #(.LINES(16), .WORDS_PER_LINE(WPL)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CPU_RD    (CPU_RD),
        .CPU_WR    (CPU_WR),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WDATA (CPU_WDATA),
        .CPU_RDATA (CPU_RDATA),
        .STALL     (STALL),
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_READY (MEM_READY)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_CNT   (HIT_CNT),
        .MISS_CNT  (MISS_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic        miss;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] mem [logic [31:0]];
    vec_t        vecs [13];
    int          checks = 0;
    int          errors = 0;
    int          rdy_period = 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input string name);
        int   stalls = 0;
        bit   done = 0;
        sb_t  e;
        logic [31:0] line;
        CPU_RD    = v.rd;
        CPU_WR    = v.wr;
        CPU_ADDR  = v.addr;
        CPU_WDATA = v.wdata;
        if (v.wr) begin
            sb_q.push_back('{wr: 1'b1, addr: {v.addr[31:2], 2'b00}, data: v.wdata});
        end else if (v.rd && v.miss) begin
            line = {v.addr[31:4], 4'h0};
            for (int k = 0; k < WPL; k++) begin
                sb_q.push_back('{wr: 1'b0, addr: line + 32'(4 * k), data: mem_rd(line + 32'(4 * k))});
            end
        end
        for (int c = 0; c < 200 && !done; c++) begin
            MEM_READY = (c % rdy_period) == 0;
            MEM_RDATA = MEM_RD ? mem_rd(MEM_ADDR) : 32'h0;
            @(negedge CLK);
            if (sb_q.size() == 0) begin
                check({name, "/mem_idle"}, {30'h0, MEM_RD, MEM_WR}, 32'h0);
            end else if (MEM_RD || MEM_WR) begin
                check({name, "/mem_op"}, {30'h0, MEM_RD, MEM_WR}, {30'h0, !sb_q[0].wr, sb_q[0].wr});
                check({name, "/mem_addr"}, MEM_ADDR, sb_q[0].addr);
                if (sb_q[0].wr) check({name, "/mem_wdata"}, MEM_WDATA, sb_q[0].data);
                if (MEM_READY) begin
                    e = sb_q.pop_front();
                    if (e.wr) mem[e.addr] = e.data;
                end
            end
            if (!STALL) begin
                check({name, "/rdata"}, CPU_RDATA, v.rdata);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge CLK);
            #1;
        end
        check({name, "/timeout"}, {31'h0, done}, 32'h1);
        check({name, "/stall_cycles"}, 32'(stalls), 32'(v.stall));
        check({name, "/sb_drained"}, 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    initial begin
        vec_t v;
        RST = 1'b1; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
        MEM_RDATA = '0; MEM_READY = 1'b0;
        for (int k = 0; k < WPL; k++) mem[32'h40 + 32'(4 * k)] = 32'h11 * 32'(k + 1);

        //           rd    wr    addr          wdata         stall miss  rdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        5, 1'b1, 32'h0000_0011};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,        0, 1'b0, 32'h0000_0033};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF, 1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h12345678, 1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        5, 1'b1, 32'h12345678};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0140, 32'h0,        5, 1'b1, 32'h5A5A_0140};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        5, 1'b1, 32'h0000_0011};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        0, 1'b0, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,        0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_004C, 32'hCAFEF00D, 1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_004C, 32'h0,        0, 1'b0, 32'hCAFEF00D};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_004F, 32'h0,        0, 1'b0, 32'hCAFEF00D};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset/stall", {31'h0, STALL}, 32'h0);
        check("reset/rdata", CPU_RDATA, 32'h0);
        check("reset/mem_rd", {31'h0, MEM_RD}, 32'h0);
        check("reset/mem_wr", {31'h0, MEM_WR}, 32'h0);
        check("reset/mem_addr", MEM_ADDR, 32'h0);
        check("reset/mem_wdata", MEM_WDATA, 32'h0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 13; i++) run_access(vecs[i], $sformatf("vec%0d", i));

        // Slow memory: ready only every 4th cycle, address must hold meanwhile.
        rdy_period = 4;
        v = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 17, 1'b1, 32'h5A5A_0080};
        run_access(v, "slow_miss");
        rdy_period = 1;

        // Reset after the second refill beat of an uncached line.
        CPU_RD = 1'b1; CPU_WR = 1'b0; CPU_ADDR = 32'h0000_00C0; MEM_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            MEM_RDATA = MEM_RD ? mem_rd(MEM_ADDR) : 32'h0;
            @(negedge CLK);
            check($sformatf("rst_seq/stall%0d", c), {31'h0, STALL}, 32'h1);
            if (c > 0) check($sformatf("rst_seq/addr%0d", c), MEM_ADDR, 32'h0000_00C0 + 32'(4 * (c - 1)));
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        #1;
        check("rst_seq/mem_rd_drop", {31'h0, MEM_RD}, 32'h0);
        check("rst_seq/mem_addr_zero", MEM_ADDR, 32'h0);
        CPU_RD = 1'b0;
        #1;
        check("rst_seq/stall_idle", {31'h0, STALL}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 5, 1'b1, 32'h0000_0011};
        run_access(v, "post_rst_40");
        v = '{1'b1, 1'b0, 32'h0000_00C4, 32'h0, 5, 1'b1, 32'h5A5A_00C4};
        run_access(v, "post_rst_C4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, read-allocate data cache controller for the RV32 core's memory stage. It serves CPU loads and stores from an internal line array and refills lines from main memory over a ready-based handshake. It asserts STALL to freeze the pipeline on misses and write-throughs. CPU_RDATA feeds the memory-data input of the write-back select mux.

## Interface
- LINES, 16: number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥2.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CPU_RD  in  1  load request; held stable while STALL=1.
- CPU_WR  in  1  store request; held stable while STALL=1; has priority if CPU_RD is also high.
- CPU_ADDR  in  32  byte address; bits [1:0] ignored (word accesses only).
- CPU_WDATA  in  32  store data.
- CPU_RDATA  out  32  load data; valid in the cycle STALL=0 with CPU_RD=1; 0 otherwise.
- STALL  out  1  freezes the pipeline.
- MEM_RD / MEM_WR  out  1 each  memory read / write request, held until MEM_READY.
- MEM_ADDR  out  32  word-aligned memory address.
- MEM_WDATA  out  32  write-through data.
- MEM_RDATA  in  32  refill data, valid when MEM_READY=1 during MEM_RD.
- MEM_READY  in  1  completes the current request; ignored when no request is active.

## Operation
- Address split: offset = [log2(W)+1:2], index = next log2(LINES) bits, tag = the remaining upper bits. With defaults: offset [3:2], index [7:4], tag [31:8].
- Storage per line: valid bit, tag, W data words. RST clears all valid bits; data and tags are not reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, read hit: CPU_RDATA is combinational from the array; STALL=0.
- IDLE, read miss: STALL=1; go to REFILL with word counter = 0.
- IDLE, CPU_WR (hit or miss): STALL=1; go to WRITE.
- REFILL: MEM_RD=1, MEM_ADDR={tag, index, counter, 2'b00}, STALL=1.
  - On MEM_READY: store MEM_RDATA into word[counter] and increment the counter.
  - On the last word: set valid, write the tag, return to IDLE. The access then hits.
- WRITE: MEM_WR=1, MEM_ADDR={CPU_ADDR[31:2], 2'b00}, MEM_WDATA=CPU_WDATA.
  - STALL = !MEM_READY.
  - On MEM_READY: if hit, update the cached word in the same edge; return to IDLE.
  - On miss: no allocation.
- Neither CPU_RD nor CPU_WR in IDLE: STALL=0, no memory traffic.
- Reset mid-operation: the FSM goes to IDLE immediately, MEM_RD/MEM_WR drop asynchronously, and a partially refilled line stays invalid.

## Timing
- Reset values: STALL=0, CPU_RDATA=0, MEM_RD=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0; state IDLE; counter 0.
- Read hit: 0 stall cycles.
- Read miss with MEM_READY tied high: STALL=1 for W+1 cycles (1 in IDLE, W in REFILL). Data is returned in the following IDLE cycle.
- Each extra MEM_READY-low cycle adds one stall cycle. MEM_ADDR is stable while a request is pending.
- Store with MEM_READY tied high: 1 stall cycle (IDLE). The store completes in the WRITE cycle.
- The counter wraps from W-1 to 0 only on the IDLE transition.

## Configuration
- DCACHE_STATS_EN defined: adds outputs HIT_CNT[31:0] and MISS_CNT[31:0], both reset to 0 and wrapping at 2^32.
  - MISS_CNT increments on each IDLE→REFILL transition.
  - HIT_CNT increments on each IDLE read hit, except the hit immediately following a REFILL.
- DCACHE_STATS_EN undefined: these ports and counters do not exist.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, REFILL, WRITE);
  - localparams for offset, index and tag widths, derived from LINES and WORDS_PER_LINE;
  - address field extraction functions.
- Sub-module dcache_array holds valid, tag and data storage, with:
  - combinational read port: index, offset → valid, tag, word;
  - synchronous write ports: word write, and tag/valid write;
  - asynchronous valid clear.

## Test plan
- Reset, read 0x40 with MEM_READY high and refill data 0x11, 0x22, 0x33, 0x44 → MEM_RD addresses 0x40, 0x44, 0x48, 0x4C; STALL high 5 cycles; CPU_RDATA=0x11.
- Then read 0x48 → STALL=0 in the same cycle, CPU_RDATA=0x33, no MEM_RD.
- Write 0xDEADBEEF to 0x44 → MEM_WR with address 0x44, 1 stall cycle; then read 0x44 → hit, 0xDEADBEEF.
- Write to uncached 0x200 → MEM_WR issued; a following read of 0x200 misses.
- Read 0x140 (index 4, tag 1) → refill evicts the line; a following read of 0x40 misses again.
- MEM_READY high only every 4th cycle during a miss → STALL high 17 cycles with MEM_ADDR stable.
- Assert RST after the 2nd refill word → MEM_RD=0 immediately; a following read of 0x40 misses.
